// File: rtl/dmem.sv
// dmem: data-memory responder for the RV32I core's LOAD/STORE requests.
// Word-organised synchronous RAM with byte lanes. Handles byte, halfword
// and word accesses selected by funct3 and extends load data. Every
// accepted request completes with a one-cycle ready pulse in the cycle
// after acceptance, so back-to-back accesses take 2 cycles each.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   dmem_read  in   load request (level, held until ready)
//   dmem_write in   store request (level, held until ready)
//   funct3     in   access size / signedness
//   addr       in   byte address; bits above the RAM size are ignored
//   wdata      in   right-aligned store data
//   rdata      out  extended load result, holds until the next response
//   ready      out  one-cycle completion pulse
//   fault      out  access rejected, meaningful only with ready
//   stall      out  request pending and not yet complete
module dmem #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        stall
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_word_p1;
  logic [2:0]    r_f3_p1;
  logic [1:0]    r_off_p1;
  logic          r_ld_ok_p1;
  logic          r_fault_p1;

  logic          w_req;
  logic          w_accept;
  logic          w_commit;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic          w_unused_addr;

  // Fault rules: misaligned halfword/word, unused load encodings, store
  // sizes above word, and simultaneous read+write.
  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f;
    f = 1'b0;
    if (rd & wr) begin
      f = 1'b1;
    end else begin
      case (f3)
        3'b000:         f = 1'b0;
        3'b001:         f = off[0];
        3'b010:         f = |off;
        3'b100, 3'b101: f = wr | (f3[0] & off[0]);
        default:        f = 1'b1;
      endcase
    end
    return f;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    logic [31:0]        res;
    sh  = word >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  res = 32'(sb);
      3'b001:  res = 32'(shw);
      3'b100:  res = {24'h0, sh[7:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_req         = dmem_read | dmem_write;
  assign w_idx         = addr[AW+1:2];
  assign w_off         = addr[1:0];
  assign w_unused_addr = ^addr[31:AW+2];
  assign w_fault       = access_fault(dmem_read, dmem_write, funct3, w_off);
  assign w_be          = (dmem_write & ~w_fault) ? lane_enable(funct3, w_off) : 4'b0000;
  // Replicate the narrow store data across the word; the lane enables pick
  // which copy actually lands.
  assign w_wlane       = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                         (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
  // Reset wins over acceptance in the same cycle.
  assign w_commit      = w_accept & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    ready       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        ready       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: accept edge, RAM write and pre-write read ----
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_word_p1 <= r_mem[w_idx];
      r_f3_p1   <= funct3;
      r_off_p1  <= w_off;
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_ok_p1 <= 1'b0;
      r_fault_p1 <= 1'b0;
    end else if (w_accept) begin
      r_ld_ok_p1 <= dmem_read & ~w_fault;
      r_fault_p1 <= w_fault;
    end
  end

  // ---- stage p1: response outputs ----
  // rdata depends only on registers that change at acceptance, so it holds
  // until the next response; stores and faults give zero.
  assign rdata = r_ld_ok_p1 ? load_extend(r_word_p1, r_f3_p1, r_off_p1) : 32'h0;
  assign fault = ready & r_fault_p1;
  assign stall = w_req & ~ready;

endmodule

// File: tb/tb_dmem.sv
module tb_dmem;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;
  logic        stall;

  int checks = 0;
  int errors = 0;

  logic [7:0] mmem [4*DEPTH];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
    string       name;
  } vec_t;

  vec_t tbl[$];

  dmem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .fault(fault), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ef, input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.er = er; v.ef = ef; v.name = name;
    tbl.push_back(v);
  endfunction

  // Reference: byte-addressed memory, access size from funct3, alignment by
  // modulo, sign extension by subtracting 2^bits when the top bit is set.
  task automatic model_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] er, output logic ef);
    int     ba;
    int     size;
    bit     sgn;
    longint v;
    ba = int'(a % 32'(4*DEPTH));
    ef = 1'b0; er = 32'h0; size = 1; sgn = 1'b0;
    if (rd && wr) ef = 1'b1;
    else if (rd) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: ef = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: ef = 1'b1;
      endcase
    end
    if (!ef && (ba % size) != 0) ef = 1'b1;
    if (!ef) begin
      if (rd) begin
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(mmem[ba+i]) << (8*i));
        if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
        er = v[31:0];
      end else begin
        for (int i = 0; i < size; i++) mmem[ba+i] = wd[8*i +: 8];
      end
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input string name);
    int n;
    @(negedge clk);
    dmem_read = rd; dmem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    check({name, "_stall_req"}, 32'(stall), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 4);
    check({name, "_latency"}, n, 1);
    check({name, "_rdata"}, rdata, er);
    check({name, "_fault"}, 32'(fault), 32'(ef));
    check({name, "_stall_resp"}, 32'(stall), 32'd0);
    dmem_read = 1'b0; dmem_write = 1'b0;
    @(posedge clk); #1;
    check({name, "_ready_pulse"}, 32'(ready), 32'd0);
    check({name, "_rdata_hold"}, rdata, er);
  endtask

  task automatic model_and_access(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input string name);
    logic [31:0] er;
    logic        ef;
    model_access(rd, wr, f3, a, wd, er, ef);
    access(rd, wr, f3, a, wd, er, ef, name);
  endtask

  task automatic reset_in_resp(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] er_resp,
                               input string name);
    logic [31:0] er;
    logic        ef;
    model_access(rd, wr, 3'd2, a, wd, er, ef);
    @(negedge clk);
    dmem_read = rd; dmem_write = wr; funct3 = 3'd2; addr = a; wdata = wd;
    @(posedge clk); #1;
    check({name, "_ready"}, 32'(ready), 32'd1);
    check({name, "_rdata"}, rdata, er_resp);
    rst = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0;
    @(posedge clk); #1;
    check({name, "_rst_ready"}, 32'(ready), 32'd0);
    check({name, "_rst_rdata"}, rdata, 32'h0);
    check({name, "_rst_fault"}, 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] er;
    logic        ef;
    for (int i = 0; i < 4*DEPTH; i++) mmem[i] = 8'h00;

    add(0, 1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h00000000, 0, "sw10");
    add(1, 0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 0, "lw10_a");
    add(1, 0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 0, "lb13");
    add(1, 0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 0, "lbu13");
    add(1, 0, 3'd1, 32'h12,   32'h0,        32'hFFFFDEAD, 0, "lh12");
    add(1, 0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 0, "lhu10");
    add(0, 1, 3'd0, 32'h11,   32'h12345655, 32'h00000000, 0, "sb11");
    add(1, 0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 0, "lw10_b");
    add(1, 0, 3'd4, 32'h11,   32'h0,        32'h00000055, 0, "lbu11");
    add(0, 1, 3'd1, 32'h12,   32'h0000CAFE, 32'h00000000, 0, "sh12");
    add(1, 0, 3'd2, 32'h10,   32'h0,        32'hCAFE55EF, 0, "lw10_c");
    add(1, 0, 3'd1, 32'h10,   32'h0,        32'h000055EF, 0, "lh10");
    add(1, 0, 3'd2, 32'h12,   32'h0,        32'h00000000, 1, "lw12_mis");
    add(0, 1, 3'd1, 32'h13,   32'hFFFFFFFF, 32'h00000000, 1, "sh13_mis");
    add(1, 0, 3'd3, 32'h10,   32'h0,        32'h00000000, 1, "ld_f011");
    add(1, 0, 3'd6, 32'h10,   32'h0,        32'h00000000, 1, "ld_f110");
    add(0, 1, 3'd3, 32'h10,   32'hFFFFFFFF, 32'h00000000, 1, "st_f011");
    add(0, 1, 3'd4, 32'h10,   32'hFFFFFFFF, 32'h00000000, 1, "st_f100");
    add(1, 1, 3'd2, 32'h10,   32'hFFFFFFFF, 32'h00000000, 1, "rd_and_wr");
    add(0, 1, 3'd2, 32'h11,   32'hFFFFFFFF, 32'h00000000, 1, "sw11_mis");
    add(1, 0, 3'd2, 32'h10,   32'h0,        32'hCAFE55EF, 0, "lw10_d");
    add(0, 1, 3'd2, 32'h1010, 32'hA5A5A5A5, 32'h00000000, 0, "sw1010");
    add(1, 0, 3'd2, 32'h10,   32'h0,        32'hA5A5A5A5, 0, "lw10_wrap");
    add(1, 0, 3'd0, 32'h10,   32'h0,        32'hFFFFFFA5, 0, "lb10");

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven directed vectors; the model shadows every store.
    foreach (tbl[i]) begin
      model_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, er, ef);
      access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].ef, tbl[i].name);
    end

    // Request held across RESP: accepted again only in the following IDLE.
    @(negedge clk);
    dmem_read = 1'b1; funct3 = 3'd2; addr = 32'h10;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("held_ready", 32'(ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) check("held_rdata", rdata, 32'hA5A5A5A5);
    end
    dmem_read = 1'b0;

    // Reset has priority over acceptance.
    @(negedge clk);
    rst = 1'b1; dmem_read = 1'b1; funct3 = 3'd2; addr = 32'h10;
    @(posedge clk); #1;
    check("rstprio_ready0", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; dmem_read = 1'b0;
    @(posedge clk); #1;
    check("rstprio_ready1", 32'(ready), 32'd0);

    // Reset during RESP of a load and of a store.
    reset_in_resp(1'b1, 1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, "rstresp_lw");
    reset_in_resp(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0, "rstresp_sw");
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11111111, 1'b0, "lw20_after_rst");

    // Randomised: initialise a 64-byte window, then mixed accesses with aliases.
    for (int w = 0; w < 16; w++)
      model_and_access(1'b0, 1'b1, 3'd2, 32'(w*4), $urandom, "rnd_init");
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      rd  = (sel <= 5);
      wr  = (sel == 0) || (sel >= 6);
      a   = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
      model_and_access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end
endmodule
